// File: rtl/wb_pkg.sv
// Shared widths, queue depth and the queued-writeback entry format.
// Every writeback_unit file imports this package.
package wb_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int DEPTH  = 4;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;
endpackage

// File: rtl/writeback_unit_if.sv
// Result-producer, register-file write and query signals of writeback_unit.
// The slave modport is the unit; the master modport is the pipeline around it.
interface writeback_unit_if #(
   parameter int XLEN   = wb_pkg::XLEN,
   parameter int REG_AW = wb_pkg::REG_AW
);
   logic              alu_valid;
   logic [REG_AW-1:0] alu_rd;
   logic [XLEN-1:0]   alu_data;
   logic              alu_ready;
   logic              lsu_valid;
   logic [REG_AW-1:0] lsu_rd;
   logic [XLEN-1:0]   lsu_data;
   logic              lsu_ready;
   logic              wb_stall;
   logic              flush;
   logic [REG_AW-1:0] q_addr;
   logic              q_hit;
   logic [REG_AW-1:0] A3;
   logic [XLEN-1:0]   WD3;
   logic              WE3;
   logic              busy;

   modport slave (
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      input  wb_stall, flush, q_addr,
      output alu_ready, lsu_ready, q_hit, A3, WD3, WE3, busy
   );

   modport master (
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      output wb_stall, flush, q_addr,
      input  alu_ready, lsu_ready, q_hit, A3, WD3, WE3, busy
   );
endinterface

// File: rtl/wb_fifo.sv
// Circular write queue: one push and one pop per cycle, head visible combinationally,
// per-slot occupancy and rd exported for hazard lookup; storage itself is never reset.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = wb_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_clear,
   input  wb_entry_t         i_dat,
   output logic              o_full,
   output logic              o_empty,
   output wb_entry_t         o_head,
   output logic [REG_AW-1:0] o_rd [DEPTH],
   output logic [DEPTH-1:0]  o_valid
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t     r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full && !i_clear;
   assign w_pop   = i_pop && !o_empty && !i_clear;
   assign o_head  = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_dat;
   end

   // A slot is live when its distance from the read pointer is below the count.
   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      logic [PW-1:0] w_off;
      assign w_off      = PW'(i) - r_rd_ptr;
      assign o_valid[i] = ({1'b0, w_off} < r_count);
      assign o_rd[i]    = r_mem[i].rd;
   end
endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and load results into one register-file write port through a small queue.
// One cycle accept-to-write latency; LSU wins arbitration, readies drop when full or flushing.
module writeback_unit
   import wb_pkg::*;
#(
   parameter int DEPTH  = wb_pkg::DEPTH,
   parameter int XLEN   = wb_pkg::XLEN,
   parameter int REG_AW = wb_pkg::REG_AW
) (
   input  logic             clk,
   input  logic             rst_n,
   writeback_unit_if.slave  wb
);
   logic              w_full;
   logic              w_empty;
   logic              w_lsu_rdy;
   logic              w_alu_rdy;
   logic              w_lsu_xfer;
   logic              w_alu_xfer;
   logic              w_push;
   logic              w_pop;
   wb_entry_t         w_push_dat;
   wb_entry_t         w_head;
   logic [REG_AW-1:0] w_rd [DEPTH];
   logic [DEPTH-1:0]  w_valid;
   logic [DEPTH-1:0]  w_match;

   // Readiness looks only at the registered count, never at this cycle's pop.
   assign w_lsu_rdy    = rst_n && !w_full && !wb.flush;
   assign w_alu_rdy    = w_lsu_rdy && !wb.lsu_valid;
   assign wb.lsu_ready = w_lsu_rdy;
   assign wb.alu_ready = w_alu_rdy;

   assign w_lsu_xfer = wb.lsu_valid && w_lsu_rdy;
   assign w_alu_xfer = wb.alu_valid && w_alu_rdy;
   assign w_push     = (w_lsu_xfer && (wb.lsu_rd != '0)) ||
                       (w_alu_xfer && (wb.alu_rd != '0));

   always_comb begin
      w_push_dat.rd   = wb.alu_rd;
      w_push_dat.data = wb.alu_data;
      if (w_lsu_xfer) begin
         w_push_dat.rd   = wb.lsu_rd;
         w_push_dat.data = wb.lsu_data;
      end
   end

   assign w_pop  = !w_empty && !wb.wb_stall && !wb.flush;
   assign wb.WE3 = w_pop;
   assign wb.A3  = w_pop ? w_head.rd   : REG_AW'(0);
   assign wb.WD3 = w_pop ? w_head.data : XLEN'(0);
   assign wb.busy = !w_empty;

   for (genvar i = 0; i < DEPTH; i++) begin : g_hit
      assign w_match[i] = w_valid[i] && (w_rd[i] == wb.q_addr);
   end
   assign wb.q_hit = (wb.q_addr != REG_AW'(0)) && (|w_match);

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (wb.flush),
      .i_dat   (w_push_dat),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head),
      .o_rd    (w_rd),
      .o_valid (w_valid)
   );
endmodule

// File: tb/tb_writeback_unit.sv
// Directed scenarios plus random traffic for writeback_unit, scored against a queue model.
module tb_writeback_unit;
   localparam int DEPTH  = 4;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef struct {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;
   ent_t mq[$];

   always #5 clk = ~clk;

   writeback_unit_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

   writeback_unit #(
      .DEPTH  (DEPTH),
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic drive(input bit lv, input int lrd, input logic [31:0] ldat,
                        input bit av, input int ard, input logic [31:0] adat,
                        input bit stall, input bit fl, input int qa);
      bus.lsu_valid = lv;
      bus.lsu_rd    = REG_AW'(lrd);
      bus.lsu_data  = ldat;
      bus.alu_valid = av;
      bus.alu_rd    = REG_AW'(ard);
      bus.alu_data  = adat;
      bus.wb_stall  = stall;
      bus.flush     = fl;
      bus.q_addr    = REG_AW'(qa);
   endtask

   // Check every output against the queue model, then advance the model one edge.
   task automatic cycle(output bit l_acc, output bit a_acc);
      bit   e_lr, e_ar, e_we, e_hit, fl;
      ent_t h, lin, ain;
      @(negedge clk);
      fl    = bus.flush;
      e_lr  = (mq.size() < DEPTH) && !fl;
      e_ar  = e_lr && !bus.lsu_valid;
      l_acc = bus.lsu_valid && e_lr;
      a_acc = bus.alu_valid && e_ar;
      e_we  = (mq.size() > 0) && !bus.wb_stall && !fl;
      h.rd = '0;
      h.data = '0;
      if (e_we) h = mq[0];
      e_hit = 1'b0;
      foreach (mq[i]) if (bus.q_addr != 0 && mq[i].rd == bus.q_addr) e_hit = 1'b1;
      lin.rd = bus.lsu_rd;
      lin.data = bus.lsu_data;
      ain.rd = bus.alu_rd;
      ain.data = bus.alu_data;
      chk("lsu_ready", 64'(bus.lsu_ready), 64'(e_lr));
      chk("alu_ready", 64'(bus.alu_ready), 64'(e_ar));
      chk("WE3", 64'(bus.WE3), 64'(e_we));
      chk("A3", 64'(bus.A3), 64'(h.rd));
      chk("WD3", 64'(bus.WD3), 64'(h.data));
      chk("q_hit", 64'(bus.q_hit), 64'(e_hit));
      chk("busy", 64'(bus.busy), 64'(mq.size() != 0));
      @(posedge clk);
      if (fl) mq.delete();
      else begin
         if (e_we) void'(mq.pop_front());
         if (l_acc && lin.rd != 0) mq.push_back(lin);
         else if (a_acc && ain.rd != 0) mq.push_back(ain);
      end
      #1;
   endtask

   task automatic idle(input bit stall, input int qa, input int n);
      bit la, aa;
      for (int k = 0; k < n; k++) begin
         drive(0, 0, 0, 0, 0, 0, stall, 0, qa);
         cycle(la, aa);
      end
   endtask

   initial begin
      bit la, aa;
      bit lv, av, st, fl;
      int lrd, ard, qa;
      logic [31:0] ldat, adat;

      drive(0, 0, 0, 1, 3, 32'h1, 0, 0, 3);
      #2;
      chk("rst_WE3", 64'(bus.WE3), 64'd0);
      chk("rst_A3", 64'(bus.A3), 64'd0);
      chk("rst_WD3", 64'(bus.WD3), 64'd0);
      chk("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
      chk("rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_q_hit", 64'(bus.q_hit), 64'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Basic path
      drive(0, 0, 0, 1, 5, 32'h5, 0, 0, 5);
      cycle(la, aa);
      chk("basic_accept", 64'(aa), 64'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 5);
      #1;
      chk("basic_A3", 64'(bus.A3), 64'd5);
      chk("basic_WD3", 64'(bus.WD3), 64'h5);
      cycle(la, aa);
      idle(0, 5, 1);

      // LSU priority over ALU
      drive(1, 4, 32'h1234, 1, 3, 32'hAAAA0000, 0, 0, 0);
      cycle(la, aa);
      chk("prio_lsu_first", 64'({la, aa}), 64'b10);
      drive(0, 0, 0, 1, 3, 32'hAAAA0000, 0, 0, 0);
      #1;
      chk("prio_A3_first", 64'(bus.A3), 64'd4);
      cycle(la, aa);
      idle(0, 0, 2);

      // Fill while stalled, then drain in order
      for (int i = 1; i <= 4; i++) begin
         drive(0, 0, 0, 1, i, 32'h100 + 32'(i), 1, 0, 0);
         cycle(la, aa);
      end
      drive(0, 0, 0, 0, 0, 0, 1, 0, 2);
      #1;
      chk("full_q_hit2", 64'(bus.q_hit), 64'd1);
      chk("full_lsu_ready", 64'(bus.lsu_ready), 64'd0);
      cycle(la, aa);
      drive(0, 0, 0, 0, 0, 0, 1, 0, 7);
      cycle(la, aa);
      drive(1, 9, 32'h99, 0, 0, 0, 0, 0, 0);
      cycle(la, aa);
      chk("full_refuse_while_pop", 64'(la), 64'd0);
      cycle(la, aa);
      chk("ready_after_pop", 64'(la), 64'd1);
      idle(0, 9, 4);

      // x0 discard
      drive(0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0);
      cycle(la, aa);
      chk("x0_handshake", 64'(aa), 64'd1);
      idle(0, 0, 2);

      // Flush with 3 queued
      for (int i = 0; i < 3; i++) begin
         drive(1, 10 + i, 32'h200 + 32'(i), 0, 0, 0, 1, 0, 11);
         cycle(la, aa);
      end
      drive(0, 0, 0, 1, 12, 32'h55, 0, 1, 11);
      cycle(la, aa);
      drive(0, 0, 0, 1, 12, 32'h55, 0, 0, 11);
      cycle(la, aa);
      chk("post_flush_accept", 64'(aa), 64'd1);
      idle(0, 12, 2);

      // Asynchronous reset mid-drain
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 1, 6 + i, 32'h300 + 32'(i), 1, 0, 0);
         cycle(la, aa);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 7);
      #1;
      chk("pre_rst_WE3", 64'(bus.WE3), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_WE3", 64'(bus.WE3), 64'd0);
      chk("mid_rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
      chk("mid_rst_alu_ready", 64'(bus.alu_ready), 64'd0);
      chk("mid_rst_busy", 64'(bus.busy), 64'd0);
      chk("mid_rst_q_hit", 64'(bus.q_hit), 64'd0);
      mq.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(0, 7, 3);

      // Random traffic
      lv = 0; av = 0; lrd = 0; ard = 0; ldat = 0; adat = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!lv && $urandom_range(2) == 0) begin
            lv = 1; lrd = int'($urandom_range(7)); ldat = $urandom;
         end
         if (!av && $urandom_range(1) == 0) begin
            av = 1; ard = int'($urandom_range(7)); adat = $urandom;
         end
         st = ($urandom_range(3) == 0);
         fl = ($urandom_range(31) == 0);
         qa = int'($urandom_range(7));
         drive(lv, lrd, ldat, av, ard, adat, st, fl, qa);
         cycle(la, aa);
         if (la) lv = 0;
         if (aa) av = 0;
      end
      idle(0, 0, 6);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
